mem_stall_responder: RTL and testbench
======================================

# mem_stall_responder

Multi-cycle data/instruction memory responder that sits on the memory side of the pipeline's `stall_from_mem` / `done_reading` handshake. It accepts one read or write request at a time, holds the requester with `Stall` for a fixed latency, then pulses `Done` with read data. It flags illegal requests on `err`, matching the error-trap style used across the processor.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `Done`; legal range 1..15.
- `DEPTH_LOG2`, default 8: log2 of the backing-store depth in 16-bit words.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `Rd` input 1: read request.
- `Wr` input 1: write request.
- `Addr` input 16: byte address. Must be even. Word index is `Addr[DEPTH_LOG2:1]`.
- `DataIn` input 16: write data.
- `DataOut` output 16: read data. Registered, valid in the `Done` cycle of a read.
- `Stall` output 1: requester must hold its pipeline.
- `Done` output 1: one-cycle completion pulse.
- `err` output 1: illegal request presented this cycle.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, accept condition: a request is accepted when exactly one of `Rd`/`Wr` is high and `Addr[0]`=0.
  - Latch op, word index, and `DataIn`.
  - Load the counter with `LATENCY-1`.
  - Go to DONE if `LATENCY`=1, otherwise to BUSY.
- IDLE, illegal request: `Rd`&`Wr`, or `Addr[0]`=1 with `Rd`|`Wr`.
  - `err`=1 combinationally that cycle.
  - No access, no state change, `Stall`=0.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to DONE.
  - On the edge entering DONE:
    - a read captures `mem[idx]` into `DataOut`;
    - a write performs `mem[idx]<=data`.
- DONE: `Done`=1 and `Stall`=0.
  - `Rd`/`Wr` are ignored, so a requester still holding its request is not re-accepted.
  - `err`=0.
  - Next state is IDLE.
- `Stall` = (IDLE & accept) | BUSY. It is combinational from the inputs in IDLE.
- `DataOut` changes only on read completion. It holds through writes, idle, and errors.
- Inputs in BUSY and DONE are ignored, including `err` evaluation.
- Address wrap-around: address bits above `DEPTH_LOG2` are ignored, so the address wraps modulo the depth.
- A read immediately following a write to the same word returns the new data.
- Backing store is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, `DataOut`=0, `Done`=0, `Stall`=0, `err`=0.
- Reset mid-operation (BUSY or DONE): the transaction is aborted.
  - A pending write is discarded (array unmodified).
  - Outputs take their reset values immediately.
- Request presented in cycle T (accepted):
  - `Stall`=1 in T..T+LATENCY-1.
  - `Done`=1 and `Stall`=0 in T+LATENCY.
  - Read data is valid on `DataOut` from T+LATENCY until the next read completes.
- `LATENCY`=1: `Stall`=1 in T only, `Done` in T+1.
- Throughput: at most one transaction per LATENCY+1 cycles. The earliest next accept is T+LATENCY+1.
- `Done` and `Stall` are never both high.
- `err` is never high while `Stall` or `Done` is high.

## Test plan
- Write then read, default params:
  - `Wr`=1, `Addr`=16'h0010, `DataIn`=16'hBEEF at T0 → `Stall`=1 in T0..T3, `Done` at T4, `DataOut` stays 0.
  - `Rd`=1, `Addr`=16'h0010 at T5 → `Stall` in T5..T8, `Done` at T9 with `DataOut`=16'hBEEF.
- Held request: keep `Rd`=1 continuously on the same address → exactly one `Done` every 5 cycles; no accept during any DONE cycle.
- Errors:
  - `Rd`=`Wr`=1 in IDLE → `err`=1, `Stall`=0, no `Done` afterwards.
  - `Rd`=1, `Addr`=16'h0003 → `err`=1, `DataOut` unchanged.
- Wrap-around, `DEPTH_LOG2`=8: write 16'h1234 to `Addr` 16'h0002, then read `Addr` 16'h0202 → `DataOut`=16'h1234.
- Reset mid-write: `Wr` to `Addr` 16'h0020 with 16'h5555 (location previously 16'hAAAA), assert `rst` at T+2 → all outputs 0 immediately; a subsequent read of 16'h0020 returns 16'hAAAA.
- `LATENCY`=1: `Rd` at T → `Stall` only in T, `Done` at T+1, next accept possible at T+2.

Source files
------------

// File: rtl/mem_stall_responder.sv
// Multi-cycle memory responder: accepts one read/write at a time, stalls the
// requester for LATENCY cycles, then pulses Done (with read data for reads).
module mem_stall_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_is_wr;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [15:0]           r_wdata;
  logic [15:0]           r_dout;
  logic [15:0]           r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  w_req;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_fire;
  logic                  w_is_wr;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [15:0]           w_wdata;
  logic                  w_unused;

  assign w_req     = Rd | Wr;
  assign w_accept  = (Rd ^ Wr) & ~Addr[0];
  assign w_illegal = (Rd & Wr) | (Addr[0] & w_req);
  assign w_unused  = ^Addr;

  // With LATENCY=1 the access completes on the accept edge, so it must use
  // the live inputs rather than the latched copies.
  assign w_is_wr = (r_state == IDLE) ? Wr                     : r_is_wr;
  assign w_idx   = (r_state == IDLE) ? Addr[DEPTH_LOG2:1]     : r_idx;
  assign w_wdata = (r_state == IDLE) ? DataIn                 : r_wdata;
  assign w_fire  = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                   ((r_state == BUSY) && (r_cnt == 4'd1));

  always_comb begin
    w_next = r_state;
    Stall  = 1'b0;
    Done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          Stall  = 1'b1;
          w_next = (LATENCY == 1) ? DONE : BUSY;
        end else if (w_illegal) begin
          err = 1'b1;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (r_cnt == 4'd1) w_next = DONE;
      end
      DONE: begin
        Done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 16'd0;
      r_dout  <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_is_wr <= Wr;
        r_idx   <= Addr[DEPTH_LOG2:1];
        r_wdata <= DataIn;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !w_is_wr) r_dout <= r_mem[w_idx];
      // Backing store has no reset; a reset before the completion edge drops the write.
      if (w_fire && w_is_wr) r_mem[w_idx] <= w_wdata;
    end
  end

  assign DataOut = r_dout;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Directed bench for mem_stall_responder: default latency instance plus a
// LATENCY=1 instance, checked cycle by cycle against hand-computed values.
module tb_mem_stall_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        rd, wr;
  logic [15:0] addr, din, dout;
  logic        stall, done, err;
  logic        rd1, wr1;
  logic [15:0] addr1, din1, dout1;
  logic        stall1, done1, err1;

  int checks   = 0;
  int failures = 0;

  mem_stall_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(dout), .Stall(stall), .Done(done), .err(err)
  );

  mem_stall_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .clk(clk), .rst(rst), .Rd(rd1), .Wr(wr1), .Addr(addr1), .DataIn(din1),
    .DataOut(dout1), .Stall(stall1), .Done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Present one request at the start of the current cycle and follow it to Done.
  task automatic run_op(input logic i_rd, input logic i_wr, input logic [15:0] i_addr,
                        input logic [15:0] i_data, input logic [15:0] exp_dout,
                        input string tag);
    rd = i_rd; wr = i_wr; addr = i_addr; din = i_data;
    smp;
    chk({tag, " accept stall"}, {29'd0, stall, done, err}, 32'b100);
    cyc;
    rd = 1'b0; wr = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      smp;
      chk({tag, " busy"}, {29'd0, stall, done, err}, 32'b100);
      cyc;
    end
    smp;
    chk({tag, " done"}, {29'd0, stall, done, err}, 32'b010);
    chk({tag, " dout"}, {16'd0, dout}, {16'd0, exp_dout});
    cyc;
  endtask

  initial begin
    rd = 0; wr = 0; addr = 0; din = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; din1 = 0;
    rst = 1'b1;
    #2;
    chk("reset outputs", {12'd0, dout, stall, done, err, 1'b0}, 32'd0);
    chk("reset outputs l1", {12'd0, dout1, stall1, done1, err1, 1'b0}, 32'd0);
    cyc; cyc;
    rst = 1'b0;
    cyc;

    run_op(0, 1, 16'h0010, 16'hBEEF, 16'h0000, "wr beef");
    run_op(1, 0, 16'h0010, 16'h0000, 16'hBEEF, "rd beef");

    // Held read: one Done every LAT+1 cycles, never re-accepted in DONE.
    rd = 1'b1; addr = 16'h0010;
    for (int i = 0; i < 3 * (LAT + 1); i++) begin
      smp;
      if ((i % (LAT + 1)) == LAT) begin
        chk("held done", {29'd0, stall, done, err}, 32'b010);
        chk("held dout", {16'd0, dout}, 32'h0000BEEF);
      end else begin
        chk("held stall", {29'd0, stall, done, err}, 32'b100);
      end
      cyc;
    end
    rd = 1'b0;
    smp;
    chk("held release idle", {29'd0, stall, done, err}, 32'b000);
    cyc;

    rd = 1'b1; wr = 1'b1; addr = 16'h0010; din = 16'h1111;
    smp;
    chk("err rd&wr", {29'd0, stall, done, err}, 32'b001);
    cyc;
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      smp;
      chk("no done after err", {29'd0, stall, done, err}, 32'b000);
      cyc;
    end
    rd = 1'b1; addr = 16'h0003;
    smp;
    chk("err odd addr", {29'd0, stall, done, err}, 32'b001);
    chk("err dout held", {16'd0, dout}, 32'h0000BEEF);
    cyc;
    rd = 1'b0;
    smp;
    chk("odd addr no op", {29'd0, stall, done, err}, 32'b000);
    cyc;

    run_op(0, 1, 16'h0002, 16'h1234, 16'hBEEF, "wr wrap");
    run_op(1, 0, 16'h0202, 16'h0000, 16'h1234, "rd wrap");

    run_op(0, 1, 16'h0020, 16'hAAAA, 16'h1234, "wr aaaa");
    wr = 1'b1; addr = 16'h0020; din = 16'h5555;
    smp;
    chk("abort accept", {29'd0, stall, done, err}, 32'b100);
    cyc;
    wr = 1'b0;
    smp;
    chk("abort busy", {29'd0, stall, done, err}, 32'b100);
    cyc;
    rst = 1'b1;
    #1;
    chk("abort outputs", {12'd0, dout, stall, done, err, 1'b0}, 32'd0);
    cyc; cyc;
    rst = 1'b0;
    smp;
    chk("post reset idle", {29'd0, stall, done, err}, 32'b000);
    cyc;
    run_op(1, 0, 16'h0020, 16'h0000, 16'hAAAA, "rd after abort");

    // LATENCY=1 instance
    wr1 = 1'b1; addr1 = 16'h0004; din1 = 16'h7777;
    smp;
    chk("l1 wr stall", {29'd0, stall1, done1, err1}, 32'b100);
    cyc;
    smp;
    chk("l1 wr done", {29'd0, stall1, done1, err1}, 32'b010);
    chk("l1 wr dout", {16'd0, dout1}, 32'd0);
    cyc;
    wr1 = 1'b0; rd1 = 1'b1;
    smp;
    chk("l1 rd stall", {29'd0, stall1, done1, err1}, 32'b100);
    cyc;
    rd1 = 1'b0;
    smp;
    chk("l1 rd done", {29'd0, stall1, done1, err1}, 32'b010);
    chk("l1 rd dout", {16'd0, dout1}, 32'h00007777);
    cyc;
    smp;
    chk("l1 idle", {29'd0, stall1, done1, err1}, 32'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
